layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter IC, default 3, meaning input channels per output channel (IC >= 1).
REQ-002 Parameter OC, default 4, meaning output channels per layer (OC >= 1).
REQ-003 Parameter POOL_EN, default 1, meaning 1 = pooling phase per output channel, 0 = skip pooling.
REQ-004 clk  input  1  meaning the single clock; all logic on the rising edge.
REQ-005 rst  input  1  meaning synchronous, active-high reset.
REQ-006 start  input  1  meaning begin a layer; sampled only in IDLE.
REQ-007 abort  input  1  meaning synchronous return to IDLE from any state.
REQ-008 conv_done  input  1  meaning convolution engine finished the current input channel.
REQ-009 pool_done  input  1  meaning pooling engine finished.
REQ-010 busy  output  1  meaning high in every state except IDLE.
REQ-011 bias_load, c_load, tree, act, done  output  1 each  meaning one-cycle strobes (see Function).
REQ-012 conv, pool  output  1 each  meaning level, high for the whole CONV / POOL state.
REQ-013 ic_idx  output  max(1,clog2(IC))  meaning current input channel index.
REQ-014 oc_idx  output  max(1,clog2(OC))  meaning current output channel index.

Function
REQ-015 Internal state register named state, 4 bits: IDLE=0, BIAS=1, LOAD=2, CONV=3, TREE=4, ACT=5, POOL=6, NEXT=7, DONE=8; other codes -> IDLE next cycle.
REQ-016 Outputs decoded from state only (Moore): bias_load in BIAS, c_load in LOAD, conv in CONV, tree in TREE, act in ACT, pool in POOL, done in DONE.
REQ-017 IDLE: start=1 -> BIAS, ic_idx=0, oc_idx=0; otherwise stay.
REQ-018 BIAS -> LOAD after one cycle; LOAD -> CONV after one cycle.
REQ-019 CONV: hold until conv_done=1; then TREE if IC>1, ACT if IC==1 (single-channel mode, no tree strobe).
REQ-020 TREE: if ic_idx==IC-1 -> ACT, ic_idx unchanged; else ic_idx+1 and -> LOAD.
REQ-021 ACT -> POOL when POOL_EN=1, else -> NEXT.
REQ-022 POOL: hold until pool_done=1, then -> NEXT.
REQ-023 NEXT: if oc_idx==OC-1 -> DONE; else oc_idx+1, ic_idx=0, -> BIAS.
REQ-024 DONE -> IDLE after one cycle; ic_idx and oc_idx cleared to 0 on that transition.
REQ-025 conv_done outside CONV and pool_done outside POOL are ignored; conv and pool are high at least one cycle even if done is already high on entry.
REQ-026 start while busy=1 is ignored; start in the DONE cycle is ignored (needs IDLE).
REQ-027 abort has priority over every transition except rst: next state IDLE, indices 0, no done strobe.
REQ-028 Indices never exceed IC-1 / OC-1; no wrap-around increments occur.

Reset
REQ-029 rst=1 at a rising edge: state=IDLE, ic_idx=0, oc_idx=0, all outputs 0 the following cycle, regardless of current state.
REQ-030 rst has priority over abort and start.

Verification
REQ-031 IC=1, OC=1, POOL_EN=0, conv_done held 1, start at edge E0 -> states BIAS,LOAD,CONV,ACT,NEXT,DONE in cycles 1-6, tree never high, done=1 only in cycle 6, IDLE in cycle 7.
REQ-032 IC=3, OC=2, POOL_EN=0, conv_done held 1 -> 6 c_load, 6 tree, 2 bias_load, 2 act pulses; done in cycle 25; ic_idx sequence 0,1,2 per output channel.
REQ-033 IC=2, OC=1, POOL_EN=1, conv_done raised 4 cycles after each conv rise, pool_done 3 cycles after pool rise -> conv high 4 cycles each, pool high 3 cycles, then NEXT, DONE.
REQ-034 Abort asserted while in CONV with oc_idx=1 -> IDLE next cycle, busy=0, indices 0, no done; a new start then runs a full layer normally.
REQ-035 rst pulsed in POOL -> IDLE, all outputs 0 the next cycle; pulsing start again while busy=1 has no effect on the state sequence.
REQ-036 Stray conv_done=1 and pool_done=1 in IDLE, BIAS, LOAD -> no state change beyond the normal sequence.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and the controller/engines around it.
// The master side is the sequencer; the slave side drives start/abort and the engine acknowledgements.
interface layer_sequencer_if #(
  parameter int IC = 3,
  parameter int OC = 4
);
  localparam int ICW = (IC > 1) ? $clog2(IC) : 1;
  localparam int OCW = (OC > 1) ? $clog2(OC) : 1;

  logic           start;
  logic           abort;
  logic           conv_done;
  logic           pool_done;
  logic           busy;
  logic           bias_load;
  logic           c_load;
  logic           conv;
  logic           tree;
  logic           act;
  logic           pool;
  logic           done;
  logic [ICW-1:0] ic_idx;
  logic [OCW-1:0] oc_idx;

  modport master (
    input  start, abort, conv_done, pool_done,
    output busy, bias_load, c_load, conv, tree, act, pool, done, ic_idx, oc_idx
  );

  modport slave (
    output start, abort, conv_done, pool_done,
    input  busy, bias_load, c_load, conv, tree, act, pool, done, ic_idx, oc_idx
  );
endinterface

// File: rtl/layer_sequencer.sv
// Per-layer control FSM: bias, per-input-channel load/conv/tree, activation, optional pooling.
// Moore outputs one cycle after the deciding edge; engines stall it only by withholding conv_done/pool_done.
module layer_sequencer #(
  parameter int IC      = 3,
  parameter int OC      = 4,
  parameter int POOL_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  layer_sequencer_if.master bus
);
  localparam int ICW = (IC > 1) ? $clog2(IC) : 1;
  localparam int OCW = (OC > 1) ? $clog2(OC) : 1;

  localparam logic [ICW-1:0] IC_LAST = ICW'(IC - 1);
  localparam logic [OCW-1:0] OC_LAST = OCW'(OC - 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_BIAS = 4'd1;
  localparam logic [3:0] S_LOAD = 4'd2;
  localparam logic [3:0] S_CONV = 4'd3;
  localparam logic [3:0] S_TREE = 4'd4;
  localparam logic [3:0] S_ACT  = 4'd5;
  localparam logic [3:0] S_POOL = 4'd6;
  localparam logic [3:0] S_NEXT = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  logic [3:0]     state_q, state_d;
  logic [ICW-1:0] ic_idx_q, ic_idx_d;
  logic [OCW-1:0] oc_idx_q, oc_idx_d;

  always_comb begin
    state_d  = state_q;
    ic_idx_d = ic_idx_q;
    oc_idx_d = oc_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_BIAS;
          ic_idx_d = '0;
          oc_idx_d = '0;
        end
      end
      S_BIAS: state_d = S_LOAD;
      S_LOAD: state_d = S_CONV;
      S_CONV: begin
        // A single input channel has nothing to accumulate, so the tree step is skipped.
        if (bus.conv_done) begin
          state_d = (IC > 1) ? S_TREE : S_ACT;
        end
      end
      S_TREE: begin
        if (ic_idx_q == IC_LAST) begin
          state_d = S_ACT;
        end else begin
          ic_idx_d = ic_idx_q + ICW'(1);
          state_d  = S_LOAD;
        end
      end
      S_ACT: state_d = (POOL_EN != 0) ? S_POOL : S_NEXT;
      S_POOL: begin
        if (bus.pool_done) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (oc_idx_q == OC_LAST) begin
          state_d = S_DONE;
        end else begin
          oc_idx_d = oc_idx_q + OCW'(1);
          ic_idx_d = '0;
          state_d  = S_BIAS;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        ic_idx_d = '0;
        oc_idx_d = '0;
      end
      default: begin
        state_d  = S_IDLE;
        ic_idx_d = '0;
        oc_idx_d = '0;
      end
    endcase

    if (bus.abort) begin
      state_d  = S_IDLE;
      ic_idx_d = '0;
      oc_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ic_idx_q <= '0;
      oc_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ic_idx_q <= ic_idx_d;
      oc_idx_q <= oc_idx_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.bias_load = (state_q == S_BIAS);
  assign bus.c_load    = (state_q == S_LOAD);
  assign bus.conv      = (state_q == S_CONV);
  assign bus.tree      = (state_q == S_TREE);
  assign bus.act       = (state_q == S_ACT);
  assign bus.pool      = (state_q == S_POOL);
  assign bus.done      = (state_q == S_DONE);
  assign bus.ic_idx    = ic_idx_q;
  assign bus.oc_idx    = oc_idx_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Three sequencer configurations driven in lockstep against a schedule-based reference model.
module tb_layer_sequencer;
  function automatic int cfg_ic(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 2;
  endfunction
  function automatic int cfg_oc(input int g);
    return (g == 1) ? 2 : 1;
  endfunction
  function automatic int cfg_pe(input int g);
    return (g == 2) ? 1 : 0;
  endfunction
  // cycle (1 = first cycle after the start edge) in which done is expected on the directed first layer
  function automatic int done_at(input int g);
    return (g == 0) ? 6 : (g == 1) ? 25 : 19;
  endfunction

  typedef enum logic [3:0] {
    PH_BIAS, PH_LOAD, PH_CONV, PH_TREE, PH_ACT, PH_POOL, PH_NEXT, PH_DONE
  } phase_e;

  typedef struct packed {
    phase_e     ph;
    logic [7:0] ic;
    logic [7:0] oc;
    logic       fin;
  } step_t;

  localparam int DIRECTED_END = 45;
  localparam int N_CYCLES     = 3000;

  logic        clk;
  logic [2:0]  rst_a, start_a, abort_a, cd_a, pd_a;
  logic [23:0] obs_a [3];

  step_t sched [3][256];
  int    head [3];
  int    tail [3];
  int    start_cyc [3];
  logic [2:0] first_layer, did_abort, did_rst;
  int    n_cmp, n_bad;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int P_IC = cfg_ic(g);
    localparam int P_OC = cfg_oc(g);
    localparam int P_PE = cfg_pe(g);

    layer_sequencer_if #(.IC(P_IC), .OC(P_OC)) bus ();

    layer_sequencer #(.IC(P_IC), .OC(P_OC), .POOL_EN(P_PE)) dut (
      .clk (clk),
      .rst (rst_a[g]),
      .bus (bus.master)
    );

    assign bus.start     = start_a[g];
    assign bus.abort     = abort_a[g];
    assign bus.conv_done = cd_a[g];
    assign bus.pool_done = pd_a[g];
    assign obs_a[g] = {bus.busy, bus.bias_load, bus.c_load, bus.conv, bus.tree,
                       bus.act, bus.pool, bus.done, 8'(bus.ic_idx), 8'(bus.oc_idx)};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int i, input phase_e ph, input int ic, input int oc, input logic fin);
    step_t s;
    s.ph  = ph;
    s.ic  = 8'(ic);
    s.oc  = 8'(oc);
    s.fin = fin;
    sched[i][tail[i]] = s;
    tail[i]++;
  endtask

  // Whole-layer cycle schedule; 'fin' marks the cycle in which the engine acknowledges.
  task automatic build(input int i, input bit directed);
    int nic;
    int noc;
    int d;
    nic = cfg_ic(i);
    noc = cfg_oc(i);
    head[i] = 0;
    tail[i] = 0;
    for (int o = 0; o < noc; o++) begin
      push(i, PH_BIAS, 0, o, 1'b0);
      for (int c = 0; c < nic; c++) begin
        push(i, PH_LOAD, c, o, 1'b0);
        d = directed ? ((i == 2) ? 4 : 1) : int'($urandom_range(1, 5));
        for (int k = 1; k <= d; k++) push(i, PH_CONV, c, o, k == d);
        if (nic > 1) push(i, PH_TREE, c, o, 1'b0);
      end
      push(i, PH_ACT, nic - 1, o, 1'b0);
      if (cfg_pe(i) != 0) begin
        d = directed ? 3 : int'($urandom_range(1, 4));
        for (int k = 1; k <= d; k++) push(i, PH_POOL, nic - 1, o, k == d);
      end
      push(i, PH_NEXT, nic - 1, o, 1'b0);
    end
    push(i, PH_DONE, nic - 1, noc - 1, 1'b0);
  endtask

  function automatic logic [23:0] expect_of(input int i);
    logic [23:0] v;
    step_t s;
    v = '0;
    if (head[i] == tail[i]) return v;
    s = sched[i][head[i]];
    v[23] = 1'b1;
    case (s.ph)
      PH_BIAS: v[22] = 1'b1;
      PH_LOAD: v[21] = 1'b1;
      PH_CONV: v[20] = 1'b1;
      PH_TREE: v[19] = 1'b1;
      PH_ACT:  v[18] = 1'b1;
      PH_POOL: v[17] = 1'b1;
      PH_DONE: v[16] = 1'b1;
      default: ;
    endcase
    v[15:8] = s.ic;
    v[7:0]  = s.oc;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_a = '1;
    start_a = '0;
    abort_a = '0;
    cd_a = '0;
    pd_a = '0;
    first_layer = '0;
    did_abort = '0;
    did_rst = '0;
    for (int i = 0; i < 3; i++) begin
      head[i] = 0;
      tail[i] = 0;
      start_cyc[i] = 0;
    end

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        logic [23:0] e;
        e = expect_of(i);
        n_cmp++;
        assert (obs_a[i] === e) else begin
          n_bad++;
          $error("FAIL outputs cfg%0d cycle %0d: observed %h expected %h", i, cyc, obs_a[i], e);
        end
        if (first_layer[i] && obs_a[i][16] === 1'b1) begin
          n_cmp++;
          assert (cyc - start_cyc[i] == done_at(i)) else begin
            n_bad++;
            $error("FAIL done_cycle cfg%0d: observed %0d expected %0d", i, cyc - start_cyc[i], done_at(i));
          end
          first_layer[i] = 1'b0;
        end
      end
      if (cyc == DIRECTED_END) begin
        n_cmp++;
        assert (first_layer === 3'b000) else begin
          n_bad++;
          $error("FAIL first_layer_done: observed pending %b expected %b", first_layer, 3'b000);
        end
      end

      for (int i = 0; i < 3; i++) begin
        logic  idle, rs, ab, st, cd, pd;
        step_t f;
        idle = (head[i] == tail[i]);
        f    = sched[i][head[i]];
        rs   = (cyc < 3);
        ab   = 1'b0;
        st   = 1'b0;
        if (cyc >= 3 && cyc < DIRECTED_END) begin
          st = idle ? (cyc == 4) : ($urandom_range(0, 3) == 0);
        end else if (cyc >= DIRECTED_END) begin
          st = idle ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 5) == 0);
          if (!idle && f.ph == PH_CONV && f.oc == 8'd1 && !did_abort[i]) begin
            ab = 1'b1;
            did_abort[i] = 1'b1;
          end else if ($urandom_range(0, 59) == 0) begin
            ab = 1'b1;
          end
          if (!idle && f.ph == PH_POOL && !did_rst[i]) begin
            rs = 1'b1;
            did_rst[i] = 1'b1;
          end else if ($urandom_range(0, 149) == 0) begin
            rs = 1'b1;
          end
        end
        // Acknowledges are exact inside the waiting phase and random noise everywhere else.
        cd = (!idle && f.ph == PH_CONV) ? f.fin : 1'($urandom_range(0, 1));
        pd = (!idle && f.ph == PH_POOL) ? f.fin : 1'($urandom_range(0, 1));
        rst_a[i]   = rs;
        abort_a[i] = ab;
        start_a[i] = st;
        cd_a[i]    = cd;
        pd_a[i]    = pd;

        if (rs || ab) begin
          head[i] = 0;
          tail[i] = 0;
        end else if (idle) begin
          if (st) begin
            build(i, cyc < DIRECTED_END);
            if (cyc < DIRECTED_END) first_layer[i] = 1'b1;
            start_cyc[i] = cyc;
          end
        end else begin
          head[i]++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
